cp0_param: RTL and testbench

CP0_PARAM -- requirements
Module: cp0_param

---
 rtl/cp0_param.sv | 177 +++++++++++++++++
 tb/tb_cp0_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_param.sv
// CP0 register block: Status/Cause/EPC/BadVAddr/Count/Compare/PRId with a
// prescaled timer, latched hardware interrupts and exception/ERET handling.
// Same-cycle strobes resolve as exception > eret > mtc0; the timer keeps
// running through exceptions and erets.
module cp0_param #(
    parameter int          N_HW_INT  = 6,
    parameter int          TIMER_DIV = 2,
    parameter logic [31:0] PRID      = 32'h0001_8000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_HW_INT-1:0] ext_int,
    input  logic                mtc0_en,
    input  logic [4:0]          cp0_idx,
    input  logic [31:0]         cp0_wdata,
    input  logic                exception,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                in_delay_slot,
    input  logic                bad_addr_valid,
    input  logic [31:0]         bad_vaddr,
    input  logic                eret,
    output logic [31:0]         cp0_rdata,
    output logic [31:0]         epc,
    output logic                exl,
    output logic                int_req
);

    localparam int             PRE_W    = 5;
    // The prescaler is a down-counter; PRE_LOAD is the "just restarted" state,
    // so Count advances when the counter reaches 0, TIMER_DIV cycles apart.
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TIMER_DIV - 1);

    localparam logic [4:0] IDX_BADVADDR = 5'd8;
    localparam logic [4:0] IDX_COUNT    = 5'd9;
    localparam logic [4:0] IDX_COMPARE  = 5'd11;
    localparam logic [4:0] IDX_STATUS   = 5'd12;
    localparam logic [4:0] IDX_CAUSE    = 5'd13;
    localparam logic [4:0] IDX_EPC      = 5'd14;
    localparam logic [4:0] IDX_PRID     = 5'd15;

    logic [31:0]         bad_vaddr_q;
    logic [31:0]         count_q;
    logic [31:0]         compare_q;
    logic [31:0]         epc_q;
    logic [7:0]          im_q;
    logic                exl_q;
    logic                ie_q;
    logic                bd_q;
    logic                ti_q;
    logic [1:0]          ip_sw_q;
    logic [4:0]          exc_code_q;
    logic [PRE_W-1:0]    pre_q;
    logic [N_HW_INT-1:0] ext_lat_q;

    logic        wr_en;
    logic        wr_count;
    logic        wr_compare;
    logic        pre_tc;
    logic [31:0] count_inc;
    logic        ti_set;
    logic [7:0]  ip_full;

    // A write only lands when no exception or eret claims the cycle.
    assign wr_en      = mtc0_en & ~exception & ~eret;
    assign wr_count   = wr_en & (cp0_idx == IDX_COUNT);
    assign wr_compare = wr_en & (cp0_idx == IDX_COMPARE);
    assign pre_tc     = (pre_q == '0);
    assign count_inc  = count_q + 32'd1;
    assign ti_set     = pre_tc & ~wr_count & (count_inc == compare_q);

    // Assemble the 8-bit IP field: software bits, latched hardware lines, timer in bit 7.
    always_comb begin
        ip_full                = 8'h00;
        ip_full[1:0]           = ip_sw_q;
        ip_full[2 +: N_HW_INT] = ext_lat_q;
        ip_full[7]             = ip_full[7] | ti_q;
    end

    // Prescaler and Count: a Count write reloads both and swallows that cycle's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            pre_q   <= PRE_LOAD;
        end else if (wr_count) begin
            count_q <= cp0_wdata;
            pre_q   <= PRE_LOAD;
        end else if (pre_tc) begin
            count_q <= count_inc;
            pre_q   <= PRE_LOAD;
        end else begin
            pre_q   <= pre_q - 1'b1;
        end
    end

    // Compare register and timer flag; a Compare write clears TI even on a coincident match.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_compare) begin
                compare_q <= cp0_wdata;
                ti_q      <= 1'b0;
            end else if (ti_set) begin
                ti_q      <= 1'b1;
            end
        end
    end

    // Hardware interrupt lines are registered once before appearing in IP.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_lat_q <= '0;
        end else begin
            ext_lat_q <= ext_int;
        end
    end

    // Exception / eret / mtc0 updates to Status, Cause, EPC and BadVAddr in priority order.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_vaddr_q <= '0;
            epc_q       <= '0;
            im_q        <= '0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            bd_q        <= 1'b0;
            ip_sw_q     <= '0;
            exc_code_q  <= '0;
        end else if (exception) begin
            exc_code_q <= exc_code;
            if (bad_addr_valid) begin
                bad_vaddr_q <= bad_vaddr;
            end
            // A nested exception keeps the original return point.
            if (!exl_q) begin
                epc_q <= in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                bd_q  <= in_delay_slot;
                exl_q <= 1'b1;
            end
        end else if (eret) begin
            exl_q <= 1'b0;
        end else if (wr_en) begin
            case (cp0_idx)
                IDX_STATUS: begin
                    im_q  <= cp0_wdata[15:8];
                    exl_q <= cp0_wdata[1];
                    ie_q  <= cp0_wdata[0];
                end
                IDX_CAUSE: ip_sw_q <= cp0_wdata[9:8];
                IDX_EPC:   epc_q   <= cp0_wdata;
                default: ;
            endcase
        end
    end

    // Combinational readback of the currently addressed register.
    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_idx)
            IDX_BADVADDR: cp0_rdata = bad_vaddr_q;
            IDX_COUNT:    cp0_rdata = count_q;
            IDX_COMPARE:  cp0_rdata = compare_q;
            IDX_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
            IDX_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, ip_full, 1'b0, exc_code_q, 2'b00};
            IDX_EPC:      cp0_rdata = epc_q;
            IDX_PRID:     cp0_rdata = PRID;
            default:      cp0_rdata = 32'h0;
        endcase
    end

    assign epc     = epc_q;
    assign exl     = exl_q;
    assign int_req = (|(ip_full & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_param.sv
// Self-checking bench for cp0_param with default parameters.
module tb_cp0_param;

    localparam int SEL_EPC = 32;
    localparam int SEL_EXL = 33;
    localparam int SEL_INT = 34;

    logic        clk;
    logic        reset;
    logic [5:0]  ext_int;
    logic        mtc0_en;
    logic [4:0]  cp0_idx;
    logic [31:0] cp0_wdata;
    logic        exception;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        in_delay_slot;
    logic        bad_addr_valid;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] epc;
    logic        exl;
    logic        int_req;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_total = 0;
    int  n_bad   = 0;

    cp0_param dut (
        .clk            (clk),
        .reset          (reset),
        .ext_int        (ext_int),
        .mtc0_en        (mtc0_en),
        .cp0_idx        (cp0_idx),
        .cp0_wdata      (cp0_wdata),
        .exception      (exception),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .in_delay_slot  (in_delay_slot),
        .bad_addr_valid (bad_addr_valid),
        .bad_vaddr      (bad_vaddr),
        .eret           (eret),
        .cp0_rdata      (cp0_rdata),
        .epc            (epc),
        .exl            (exl),
        .int_req        (int_req)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.sel < 32) cp0_idx = 5'(e.sel);
            #1;
            case (e.sel)
                SEL_EPC: obs = epc;
                SEL_EXL: obs = {31'b0, exl};
                SEL_INT: obs = {31'b0, int_req};
                default: obs = cp0_rdata;
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        cp0_idx   = idx;
        cp0_wdata = d;
        mtc0_en   = 1'b1;
        tick();
        mtc0_en   = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                       input logic bav, input logic [31:0] bv);
        exception      = 1'b1;
        exc_code       = code;
        exc_pc         = pc;
        in_delay_slot  = ds;
        bad_addr_valid = bav;
        bad_vaddr      = bv;
        tick();
        exception      = 1'b0;
        bad_addr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ext_int = '0; mtc0_en = 1'b0; cp0_idx = '0; cp0_wdata = '0;
        exception = 1'b0; exc_code = '0; exc_pc = '0; in_delay_slot = 1'b0;
        bad_addr_valid = 1'b0; bad_vaddr = '0; eret = 1'b0;
        tick(); tick();
        reset = 1'b0;
        push("rst_status", 12, 32'h0040_0000);
        push("rst_cause", 13, 32'h0);
        push("rst_intreq", SEL_INT, 32'h0);
        push("rst_exl", SEL_EXL, 32'h0);
        push("rst_epc", SEL_EPC, 32'h0);
        push("rst_count", 9, 32'h0);
        push("prid", 15, 32'h0001_8000);
        push("idx_other", 10, 32'h0);
        drain();

        // Ignored indices and Cause software bits only
        wr(5'd8, 32'hDEAD_BEEF);
        wr(5'd15, 32'h0000_0001);
        push("wr8_ignored", 8, 32'h0);
        push("wr15_ignored", 15, 32'h0001_8000);
        drain();
        wr(5'd13, 32'hFFFF_FFFF);
        push("cause_ipsw", 13, 32'h0000_0300);
        drain();
        wr(5'd13, 32'h0);
        push("cause_ipsw_clr", 13, 32'h0);
        drain();

        // Read in the write cycle returns the old value
        cp0_idx = 5'd14; cp0_wdata = 32'h1111_2220; mtc0_en = 1'b1;
        push("epc_prewrite", 14, 32'h0);
        drain();
        tick();
        mtc0_en = 1'b0;
        push("epc_written", 14, 32'h1111_2220);
        push("epc_port", SEL_EPC, 32'h1111_2220);
        drain();

        // Timer: Compare=5, Count=0 -> Count reaches 5 ten edges after the write
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        push("count_load", 9, 32'd0);
        drain();
        repeat (9) tick();
        push("count_at4", 9, 32'd4);
        push("ti_before", 13, 32'h0);
        drain();
        tick();
        push("count_at5", 9, 32'd5);
        push("ti_set", 13, 32'h4000_8000);
        drain();
        wr(5'd11, 32'd100);
        push("ti_cleared", 13, 32'h0);
        drain();

        // Compare write coinciding with a match: clear wins
        wr(5'd11, 32'd1);
        wr(5'd9, 32'd0);
        tick();
        wr(5'd11, 32'd1);
        push("cmpclr_count", 9, 32'd1);
        push("cmpclr_ti", 13, 32'h0);
        drain();

        // Count write on a terminal prescaler cycle discards the increment
        tick();
        wr(5'd9, 32'h100);
        push("cnt_discard", 9, 32'h100);
        drain();
        tick();
        push("cnt_pre_reset", 9, 32'h100);
        drain();
        tick();
        push("cnt_next_inc", 9, 32'h101);
        drain();

        // Interrupt path
        wr(5'd12, 32'h0000_8001);
        push("status_wr", 12, 32'h0040_8001);
        drain();
        ext_int = 6'b100000;
        push("intreq_pre", SEL_INT, 32'h0);
        drain();
        tick();
        push("intreq_1edge", SEL_INT, 32'h1);
        drain();
        tick();
        push("intreq_2edge", SEL_INT, 32'h1);
        drain();
        exc(5'd0, 32'h8000_0040, 1'b0, 1'b0, 32'h0);
        push("exc_intreq", SEL_INT, 32'h0);
        push("exc_exl", SEL_EXL, 32'h1);
        push("exc_epc", SEL_EPC, 32'h8000_0040);
        drain();
        ext_int = '0;
        eret = 1'b1; tick(); eret = 1'b0;
        push("eret_exl", SEL_EXL, 32'h0);
        drain();

        // Delay-slot exception with bad address
        exc(5'd4, 32'h8000_0104, 1'b1, 1'b1, 32'h1234_5679);
        push("ds_epc", 14, 32'h8000_0100);
        push("ds_cause", 13, 32'h8000_0010);
        push("ds_badv", 8, 32'h1234_5679);
        push("ds_exl", SEL_EXL, 32'h1);
        drain();

        // Nested exception keeps EPC/BD
        exc(5'd5, 32'h8000_0200, 1'b0, 1'b0, 32'hFFFF_FFFF);
        push("nest_epc", 14, 32'h8000_0100);
        push("nest_cause", 13, 32'h8000_0014);
        push("nest_badv", 8, 32'h1234_5679);
        drain();
        eret = 1'b1; tick(); eret = 1'b0;
        push("nest_eret_exl", SEL_EXL, 32'h0);
        drain();

        // Collision: exception + eret + mtc0 EPC
        exception = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_0300; in_delay_slot = 1'b0;
        eret = 1'b1; mtc0_en = 1'b1; cp0_idx = 5'd14; cp0_wdata = 32'hAAAA_0000;
        tick();
        exception = 1'b0; eret = 1'b0; mtc0_en = 1'b0;
        push("col_exl", SEL_EXL, 32'h1);
        push("col_epc", SEL_EPC, 32'h8000_0300);
        push("col_cause", 13, 32'h0000_0020);
        drain();

        // eret beats mtc0 to Status
        eret = 1'b1; mtc0_en = 1'b1; cp0_idx = 5'd12; cp0_wdata = 32'h0000_FF02;
        tick();
        eret = 1'b0; mtc0_en = 1'b0;
        push("eret_mtc0_exl", SEL_EXL, 32'h0);
        push("eret_mtc0_status", 12, 32'h0040_8001);
        drain();

        // Count wrap onto Compare=0
        wr(5'd11, 32'h0);
        wr(5'd9, 32'hFFFF_FFFF);
        push("wrap_load", 9, 32'hFFFF_FFFF);
        drain();
        tick();
        push("wrap_hold", 9, 32'hFFFF_FFFF);
        drain();
        tick();
        push("wrap_count", 9, 32'h0);
        push("wrap_cause", 13, 32'h4000_8020);
        push("wrap_intreq", SEL_INT, 32'h1);
        drain();

        // Reset overrides concurrent strobes
        reset = 1'b1; exception = 1'b1; exc_pc = 32'h8000_0400; eret = 1'b1;
        mtc0_en = 1'b1; cp0_idx = 5'd14; cp0_wdata = 32'h5555_5555;
        tick();
        reset = 1'b0; exception = 1'b0; eret = 1'b0; mtc0_en = 1'b0;
        push("rst2_status", 12, 32'h0040_0000);
        push("rst2_cause", 13, 32'h0);
        push("rst2_intreq", SEL_INT, 32'h0);
        push("rst2_exl", SEL_EXL, 32'h0);
        push("rst2_epc", SEL_EPC, 32'h0);
        push("rst2_badv", 8, 32'h0);
        push("rst2_compare", 11, 32'h0);
        push("rst2_count", 9, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
